// File: rtl/plcpu_mem_arbiter_if.sv
// plcpu_mem_arbiter_if
//   Bundles the three requester ports (fetch, data, debug), the response and
//   stall outputs, and the memory macro port of the unified-memory arbiter.
//   Modports:
//     slave  - arbiter view: requests and mem_rdata in; acks, rdata, stalls,
//              busy and mem_* strobes out.
//     master - environment view (core, loader, memory): the mirror image.
interface plcpu_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Fetch port
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_ack;
    // Data port
    logic            dm_req;
    logic            dm_we;
    logic [DW/8-1:0] dm_wmask;
    logic [AW-1:0]   dm_addr;
    logic [DW-1:0]   dm_wdata;
    logic            dm_ack;
    // Debug / loader port
    logic            dbg_req;
    logic            dbg_we;
    logic [AW-1:0]   dbg_addr;
    logic [DW-1:0]   dbg_wdata;
    logic            dbg_ack;
    // Shared response and pipeline status
    logic [DW-1:0]   rdata;
    logic            if_stall;
    logic            dm_stall;
    logic            busy;
    // Memory macro port
    logic            mem_ce;
    logic            mem_we;
    logic [DW/8-1:0] mem_wmask;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_wmask, dm_addr, dm_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output if_ack, dm_ack, dbg_ack, rdata, if_stall, dm_stall, busy,
        output mem_ce, mem_we, mem_wmask, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_wmask, dm_addr, dm_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  if_ack, dm_ack, dbg_ack, rdata, if_stall, dm_stall, busy,
        input  mem_ce, mem_we, mem_wmask, mem_addr, mem_wdata
    );
endinterface

// File: rtl/plcpu_mem_arbiter.sv
// plcpu_mem_arbiter
//   Arbitrates a single-ported unified memory between instruction fetch, data
//   access and a debug/loader port. One transaction at a time:
//   IDLE (grant) -> ISSUE (mem_ce) -> WAIT (MEM_LAT cycles) -> RESP (ack).
//   Debug always wins; otherwise data beats fetch unless fetch has been passed
//   over STARVE_MAX times in a row.
// Ports:
//   clk  - system clock, rising edge
//   rstn - asynchronous reset, active-high (legacy name)
//   bus  - requester, status and memory signals (plcpu_mem_arbiter_if.slave)
module plcpu_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    plcpu_mem_arbiter_if.slave   bus
);
    localparam int MW = DW / 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_IF   = 2'd1;
    localparam logic [1:0] ID_DM   = 2'd2;
    localparam logic [1:0] ID_DBG  = 2'd3;

    localparam logic [3:0] LAT    = 4'(MEM_LAT);
    localparam logic [3:0] STARVE = 4'(STARVE_MAX);

    logic [1:0]    state_q, state_d;
    logic [1:0]    grant_q;
    logic [1:0]    win;
    logic [3:0]    wait_q;
    logic [3:0]    starve_q;
    logic          mem_ce_q, mem_we_q;
    logic [MW-1:0] mem_wmask_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] rdata_q;
    logic          if_ack_q, dm_ack_q, dbg_ack_q;

    // Fixed priority with a starvation override for fetch.
    always_comb begin
        win = ID_NONE;
        if (bus.dbg_req)                              win = ID_DBG;
        else if (bus.if_req && (starve_q == STARVE))  win = ID_IF;
        else if (bus.dm_req)                          win = ID_DM;
        else if (bus.if_req)                          win = ID_IF;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win != ID_NONE) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (wait_q == 4'd1) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q     <= IDLE;
            grant_q     <= ID_NONE;
            wait_q      <= '0;
            starve_q    <= '0;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            dbg_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_ce_q  <= 1'b0;
            if_ack_q  <= 1'b0;
            dm_ack_q  <= 1'b0;
            dbg_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win != ID_NONE) begin
                        grant_q  <= win;
                        mem_ce_q <= 1'b1;
                        unique case (win)
                            ID_DBG: begin
                                mem_we_q    <= bus.dbg_we;
                                mem_wmask_q <= '1;
                                mem_addr_q  <= bus.dbg_addr;
                                mem_wdata_q <= bus.dbg_wdata;
                            end
                            ID_DM: begin
                                mem_we_q    <= bus.dm_we;
                                mem_wmask_q <= bus.dm_wmask;
                                mem_addr_q  <= bus.dm_addr;
                                mem_wdata_q <= bus.dm_wdata;
                            end
                            ID_IF: begin
                                mem_we_q    <= 1'b0;
                                mem_wmask_q <= '0;
                                mem_addr_q  <= bus.if_addr;
                                mem_wdata_q <= '0;
                            end
                            default: ;
                        endcase
                    end
                    // if_req high implies some grant, so the else-branch is a
                    // dm/dbg grant that passed over a pending fetch.
                    if (!bus.if_req || (win == ID_IF)) begin
                        starve_q <= '0;
                    end else if (starve_q != STARVE) begin
                        starve_q <= starve_q + 4'd1;
                    end
                end
                ISSUE: wait_q <= LAT;
                WAIT: begin
                    wait_q <= wait_q - 4'd1;
                    if (wait_q == 4'd1) begin
                        rdata_q   <= mem_we_q ? '0 : bus.mem_rdata;
                        if_ack_q  <= (grant_q == ID_IF);
                        dm_ack_q  <= (grant_q == ID_DM);
                        dbg_ack_q <= (grant_q == ID_DBG);
                    end
                end
                default: begin
                    // RESP: drop the bus back to an all-zero idle image.
                    grant_q     <= ID_NONE;
                    mem_we_q    <= 1'b0;
                    mem_wmask_q <= '0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    rdata_q     <= '0;
                end
            endcase
        end
    end

    assign bus.mem_ce    = mem_ce_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wmask = mem_wmask_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.dbg_ack   = dbg_ack_q;
    assign bus.if_stall  = bus.if_req & ~if_ack_q;
    assign bus.dm_stall  = bus.dm_req & ~dm_ack_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
